// File: rtl/ula_seq_ctrl.sv
// ----------------------------------------------------------------------------
// ula_seq_ctrl
//
// Purpose:
//   Sequencer in front of a combinational single-digit BCD ULA
//   (sum / sub / mult / div). It accepts one command at a time over a
//   valid/ready port and checks the operands. For a legal command it drives
//   the ULA inputs, waits SETTLE_CYCLES clock edges, and then captures the ULA
//   results. It returns those results, or an error code, over a valid/ready
//   response port. This block is the only master of the ULA.
//
// Parameters:
//   SETTLE_CYCLES  number of clock edges from the accept edge to the result
//                  capture edge. The legal range is 1..15.
//
// Ports:
//   clk        in   system clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   cmd_valid  in   command present
//   cmd_ready  out  a command can be accepted (IDLE only)
//   cmd_a      in   operand a, legal 0..9
//   cmd_b      in   operand b, legal 0..9
//   cmd_op     in   0=sum 1=sub 2=mult 3=div
//   alu_a      out  ULA operand a (registered, holds between commands)
//   alu_b      out  ULA operand b (registered, holds between commands)
//   alu_op     out  ULA opcode (registered, holds between commands)
//   alu_r1     in   ULA result1 (units digit / quotient)
//   alu_r2     in   ULA result2 (carry / tens / 15 = negative)
//   rsp_valid  out  response present
//   rsp_ready  in   consumer takes the response
//   rsp_digit  out  captured result1
//   rsp_hi     out  captured result2
//   rsp_err    out  0=ok 1=operand>9 2=divide by zero
//   busy       out  high in every state except IDLE
//   done_cnt   out  error-free responses delivered, wraps 255->0
// ----------------------------------------------------------------------------
module ula_seq_ctrl #(
    parameter int unsigned SETTLE_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [7:0] cmd_a,
    input  logic [7:0] cmd_b,
    input  logic [1:0] cmd_op,
    output logic [7:0] alu_a,
    output logic [7:0] alu_b,
    output logic [1:0] alu_op,
    input  logic [7:0] alu_r1,
    input  logic [7:0] alu_r2,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [7:0] rsp_digit,
    output logic [7:0] rsp_hi,
    output logic [1:0] rsp_err,
    output logic       busy,
    output logic [7:0] done_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    localparam logic [3:0] SETTLE_INIT = 4'(SETTLE_CYCLES);
    localparam logic [1:0] OP_DIV      = 2'd3;
    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_RANGE   = 2'd1;
    localparam logic [1:0] ERR_DIV0    = 2'd2;

    state_t     state_reg,     state_next;
    logic [3:0] cnt_reg,       cnt_next;
    logic [7:0] alu_a_reg,     alu_a_next;
    logic [7:0] alu_b_reg,     alu_b_next;
    logic [1:0] alu_op_reg,    alu_op_next;
    logic [7:0] rsp_digit_reg, rsp_digit_next;
    logic [7:0] rsp_hi_reg,    rsp_hi_next;
    logic [1:0] rsp_err_reg,   rsp_err_next;
    logic [7:0] done_cnt_reg,  done_cnt_next;

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= ST_IDLE;
            cnt_reg       <= 4'd0;
            alu_a_reg     <= 8'd0;
            alu_b_reg     <= 8'd0;
            alu_op_reg    <= 2'd0;
            rsp_digit_reg <= 8'd0;
            rsp_hi_reg    <= 8'd0;
            rsp_err_reg   <= 2'd0;
            done_cnt_reg  <= 8'd0;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            alu_a_reg     <= alu_a_next;
            alu_b_reg     <= alu_b_next;
            alu_op_reg    <= alu_op_next;
            rsp_digit_reg <= rsp_digit_next;
            rsp_hi_reg    <= rsp_hi_next;
            rsp_err_reg   <= rsp_err_next;
            done_cnt_reg  <= done_cnt_next;
        end
    end

    // Next-state and datapath logic
    always_comb begin
        state_next     = state_reg;
        cnt_next       = cnt_reg;
        alu_a_next     = alu_a_reg;
        alu_b_next     = alu_b_reg;
        alu_op_next    = alu_op_reg;
        rsp_digit_next = rsp_digit_reg;
        rsp_hi_next    = rsp_hi_reg;
        rsp_err_next   = rsp_err_reg;
        done_cnt_next  = done_cnt_reg;

        case (state_reg)
            ST_IDLE: begin
                if (cmd_valid) begin
                    // The range error is checked first, so it takes priority
                    // over divide-by-zero. Rejected commands leave alu_*
                    // untouched.
                    if ((cmd_a > 8'd9) || (cmd_b > 8'd9)) begin
                        rsp_err_next   = ERR_RANGE;
                        rsp_digit_next = 8'd0;
                        rsp_hi_next    = 8'd0;
                        state_next     = ST_RESP;
                    end else if ((cmd_op == OP_DIV) && (cmd_b == 8'd0)) begin
                        rsp_err_next   = ERR_DIV0;
                        rsp_digit_next = 8'd0;
                        rsp_hi_next    = 8'd0;
                        state_next     = ST_RESP;
                    end else begin
                        alu_a_next  = cmd_a;
                        alu_b_next  = cmd_b;
                        alu_op_next = cmd_op;
                        cnt_next    = SETTLE_INIT;
                        state_next  = ST_WAIT;
                    end
                end
            end

            ST_WAIT: begin
                // The ULA was loaded on the accept edge. The capture happens
                // on the edge where the count has reached 1, which is
                // SETTLE_CYCLES edges after the accept edge.
                cnt_next = cnt_reg - 4'd1;
                if (cnt_reg == 4'd1) begin
                    rsp_digit_next = alu_r1;
                    rsp_hi_next    = alu_r2;
                    rsp_err_next   = ERR_NONE;
                    state_next     = ST_RESP;
                end
            end

            ST_RESP: begin
                if (rsp_ready) begin
                    state_next = ST_IDLE;
                    if (rsp_err_reg == ERR_NONE) begin
                        done_cnt_next = done_cnt_reg + 8'd1;
                    end
                end
            end

            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    assign cmd_ready = (state_reg == ST_IDLE);
    assign rsp_valid = (state_reg == ST_RESP);
    assign busy      = (state_reg != ST_IDLE);
    assign alu_a     = alu_a_reg;
    assign alu_b     = alu_b_reg;
    assign alu_op    = alu_op_reg;
    assign rsp_digit = rsp_digit_reg;
    assign rsp_hi    = rsp_hi_reg;
    assign rsp_err   = rsp_err_reg;
    assign done_cnt  = done_cnt_reg;

endmodule

// File: tb/tb_ula_seq_ctrl.sv
// ----------------------------------------------------------------------------
// tb_ula_seq_ctrl
//
// Directed testbench for ula_seq_ctrl, with SETTLE_CYCLES=2. A small
// behavioural BCD ULA drives alu_r1/alu_r2. Every expected value is written
// out by hand at the step that checks it.
//
// The response latency is counted in clock edges after the accept edge.
// A legal command responds SETTLE_CYCLES edges later. An error response is
// registered on the accept edge itself, so it is visible in the very next
// cycle.
// ----------------------------------------------------------------------------
module tb_ula_seq_ctrl;

    localparam int SETTLE = 2;

    logic       clk;
    logic       rst_n;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [7:0] cmd_a;
    logic [7:0] cmd_b;
    logic [1:0] cmd_op;
    logic [7:0] alu_a;
    logic [7:0] alu_b;
    logic [1:0] alu_op;
    logic [7:0] alu_r1;
    logic [7:0] alu_r2;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [7:0] rsp_digit;
    logic [7:0] rsp_hi;
    logic [1:0] rsp_err;
    logic       busy;
    logic [7:0] done_cnt;

    int vectors    = 0;
    int miscompares = 0;

    ula_seq_ctrl #(.SETTLE_CYCLES(SETTLE)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_a     (cmd_a),
        .cmd_b     (cmd_b),
        .cmd_op    (cmd_op),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_op    (alu_op),
        .alu_r1    (alu_r1),
        .alu_r2    (alu_r2),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_digit (rsp_digit),
        .rsp_hi    (rsp_hi),
        .rsp_err   (rsp_err),
        .busy      (busy),
        .done_cnt  (done_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural single-digit BCD ULA. A negative subtraction returns its
    // magnitude, with result2 set to 15.
    function automatic logic [15:0] ula(input logic [7:0] a, input logic [7:0] b,
                                        input logic [1:0] op);
        int x, y, r1, r2;
        x  = int'(a);
        y  = int'(b);
        r1 = 0;
        r2 = 0;
        case (op)
            2'd0: begin r1 = (x + y) % 10; r2 = (x + y) / 10; end
            2'd1: begin
                if (x >= y) begin r1 = x - y; r2 = 0; end
                else        begin r1 = y - x; r2 = 15; end
            end
            2'd2: begin r1 = (x * y) % 10; r2 = (x * y) / 10; end
            default: begin
                if (y != 0) begin r1 = x / y; r2 = x % y; end
            end
        endcase
        return {8'(r2), 8'(r1)};
    endfunction

    assign {alu_r2, alu_r1} = ula(alu_a, alu_b, alu_op);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Presents a command from IDLE, waits for the response (bounded), and
    // checks the latency and the response fields. It leaves rsp_valid pending.
    task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [1:0] op,
                        input int exp_lat, input logic [7:0] e_dig,
                        input logic [7:0] e_hi, input logic [1:0] e_err);
        int lat;
        check("cmd_ready_idle", cmd_ready, 1);
        cmd_a = a; cmd_b = b; cmd_op = op; cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0; cmd_a = 8'd0; cmd_b = 8'd0; cmd_op = 2'd0;
        lat = 0;
        while (!rsp_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        check("rsp_latency", lat, exp_lat);
        check("rsp_digit", rsp_digit, e_dig);
        check("rsp_hi", rsp_hi, e_hi);
        check("rsp_err", rsp_err, e_err);
    endtask

    // Completes the response handshake and checks the return to IDLE.
    task automatic consume(input logic [7:0] exp_done);
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        check("rsp_valid_clear", rsp_valid, 0);
        check("cmd_ready_back", cmd_ready, 1);
        check("done_cnt", done_cnt, exp_done);
    endtask

    initial begin
        int lat;
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_a = 8'd0; cmd_b = 8'd0;
        cmd_op = 2'd0; rsp_ready = 1'b0;
        #1;
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_done_cnt", done_cnt, 0);
        check("rst_alu_a", alu_a, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("rst_cmd_ready", cmd_ready, 1);

        // 7 + 5 = 12
        send(8'd7, 8'd5, 2'd0, SETTLE, 8'd2, 8'd1, 2'd0);
        check("alu_a_loaded", alu_a, 7);
        check("busy_resp", busy, 1);
        consume(8'd1);

        // 3 - 8 = -5; 6 * 7 = 42
        send(8'd3, 8'd8, 2'd1, SETTLE, 8'd5, 8'd15, 2'd0);
        consume(8'd2);
        send(8'd6, 8'd7, 2'd2, SETTLE, 8'd2, 8'd4, 2'd0);
        consume(8'd3);

        // Divide by zero: the ULA inputs keep 6,7,mult and done_cnt is unchanged
        send(8'd6, 8'd0, 2'd3, 0, 8'd0, 8'd0, 2'd2);
        check("div0_alu_a", alu_a, 6);
        check("div0_alu_b", alu_b, 7);
        check("div0_alu_op", alu_op, 2);
        consume(8'd3);

        // The range error beats divide-by-zero; an out-of-range b is rejected
        send(8'd12, 8'd0, 2'd3, 0, 8'd0, 8'd0, 2'd1);
        consume(8'd3);
        send(8'd4, 8'd10, 2'd0, 0, 8'd0, 8'd0, 2'd1);
        check("rng_alu_a", alu_a, 6);
        consume(8'd3);

        // 9 / 2 = 4 remainder 1
        send(8'd9, 8'd2, 2'd3, SETTLE, 8'd4, 8'd1, 2'd0);
        consume(8'd4);

        // Back-pressure: 8 * 9 = 72. The response is held for 5 cycles while
        // a new command waits on the input and must not be taken.
        send(8'd8, 8'd9, 2'd2, SETTLE, 8'd2, 8'd7, 2'd0);
        cmd_a = 8'd1; cmd_b = 8'd2; cmd_op = 2'd0; cmd_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("stall_rsp_valid", rsp_valid, 1);
            check("stall_digit", rsp_digit, 2);
            check("stall_hi", rsp_hi, 7);
            check("stall_cmd_ready", cmd_ready, 0);
            check("stall_busy", busy, 1);
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        check("hs_no_accept_busy", busy, 0);
        check("hs_cmd_ready", cmd_ready, 1);
        check("hs_alu_a", alu_a, 8);
        check("hs_done_cnt", done_cnt, 5);
        cmd_valid = 1'b0;

        // Asynchronous reset in the middle of WAIT
        cmd_a = 8'd5; cmd_b = 8'd4; cmd_op = 2'd2; cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        check("wait_busy", busy, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_busy", busy, 0);
        check("arst_rsp_valid", rsp_valid, 0);
        check("arst_alu_a", alu_a, 0);
        check("arst_alu_b", alu_b, 0);
        check("arst_alu_op", alu_op, 0);
        check("arst_digit", rsp_digit, 0);
        check("arst_hi", rsp_hi, 0);
        check("arst_err", rsp_err, 0);
        check("arst_done_cnt", done_cnt, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("arst_cmd_ready", cmd_ready, 1);

        // 256 good commands: done_cnt reaches 255, then wraps to 0
        for (int i = 0; i < 256; i++) begin
            cmd_a = 8'd1; cmd_b = 8'd1; cmd_op = 2'd0; cmd_valid = 1'b1;
            @(posedge clk); #1;
            cmd_valid = 1'b0;
            lat = 0;
            while (!rsp_valid && lat < 40) begin
                @(posedge clk); #1;
                lat++;
            end
            if (lat >= 40) check("wrap_timeout", lat, SETTLE);
            rsp_ready = 1'b1;
            @(posedge clk); #1;
            rsp_ready = 1'b0;
            if (i == 254) check("done_cnt_255", done_cnt, 255);
        end
        check("done_cnt_wrap", done_cnt, 0);
        check("wrap_last_digit", rsp_digit, 2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout vectors=%0d", vectors);
        $fatal(1, "watchdog");
    end

endmodule
